// File: rtl/mix_core_n_if.sv
// SDRAM client bus between the N-source mixer and the SDRAM access arbiter.
// The mixer is the master: it issues read/write requests and waits for the finished pulses.
interface mix_core_n_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              mix_read;
    logic              mix_write;
    logic [ADDR_W-1:0] mix_addr;
    logic [DATA_W-1:0] mix_writedata;
    logic [DATA_W-1:0] mix_readdata;
    logic              mix_read_finished;
    logic              mix_write_finished;

    modport master (
        output mix_read,
        output mix_write,
        output mix_addr,
        output mix_writedata,
        input  mix_readdata,
        input  mix_read_finished,
        input  mix_write_finished
    );

    modport slave (
        input  mix_read,
        input  mix_write,
        input  mix_addr,
        input  mix_writedata,
        output mix_readdata,
        output mix_read_finished,
        output mix_write_finished
    );
endinterface

// File: rtl/mix_core_n.sv
// N-source audio mixer: reads one sample per enabled source from SDRAM, applies gain,
// sums with saturation and writes the mixed sample to the destination track.
module mix_core_n #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int N_SRC  = 4,
    parameter int GAIN_W = 8,
    parameter int LEN_W  = 23
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           mix_start,
    input  logic                           mix_abort,
    input  logic [ADDR_W-1:0]              mix_dst_addr,
    input  logic [N_SRC-1:0][ADDR_W-1:0]   mix_src_addr,
    input  logic [N_SRC-1:0]               mix_src_en,
    input  logic [N_SRC-1:0][GAIN_W-1:0]   mix_gain,
    input  logic [LEN_W-1:0]               mix_len,
    output logic                           mix_busy,
    output logic                           mix_done,
    output logic [LEN_W-1:0]               mix_clip_count,
    mix_core_n_if.master                   bus
);

    localparam int ACC_W = DATA_W + GAIN_W + $clog2(N_SRC) + 1;
    localparam int IDX_W = $clog2(N_SRC + 1);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_READ  = 3'd2,
        S_ACC   = 3'd3,
        S_WRITE = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                        state_q;
    logic                          busy_q;
    logic                          done_q;
    logic [LEN_W-1:0]              clip_q;
    logic                          read_q;
    logic                          write_q;
    logic [ADDR_W-1:0]             addr_q;
    logic [DATA_W-1:0]             wdata_q;
    logic [ADDR_W-1:0]             dst_q;
    logic [N_SRC-1:0][ADDR_W-1:0]  src_q;
    logic [N_SRC-1:0]              en_q;
    logic [N_SRC-1:0][GAIN_W-1:0]  gain_q;
    logic [LEN_W-1:0]              len_q;
    logic signed [ACC_W-1:0]       acc_q;
    logic [LEN_W-1:0]              k_q;
    logic [IDX_W-1:0]              i_q;
    logic [DATA_W-1:0]             sample_q;
    logic                          abort_q;

    logic                          found_s;
    logic [IDX_W-1:0]              sel_i_s;
    logic signed [ACC_W-1:0]       samp_ext_s;
    logic signed [ACC_W-1:0]       gain_ext_s;
    logic signed [ACC_W-1:0]       prod_s;
    logic signed [ACC_W-1:0]       shifted_s;
    logic [ACC_W-DATA_W:0]         upper_s;
    logic                          sat_s;
    logic [DATA_W-1:0]             result_s;
    logic                          stop_s;
    logic [LEN_W-1:0]              k_inc_s;
    logic [LEN_W-1:0]              clip_inc_s;

    assign mix_busy       = busy_q;
    assign mix_done       = done_q;
    assign mix_clip_count = clip_q;
    assign bus.mix_read      = read_q;
    assign bus.mix_write     = write_q;
    assign bus.mix_addr      = addr_q;
    assign bus.mix_writedata = wdata_q;

    // Lowest-numbered enabled source at or above the current source index.
    always_comb begin
        found_s = 1'b0;
        sel_i_s = i_q;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (en_q[j] && (IDX_W'(j) >= i_q)) begin
                found_s = 1'b1;
                sel_i_s = IDX_W'(j);
            end else begin
                found_s = found_s;
                sel_i_s = sel_i_s;
            end
        end
    end

    // Gain product, output scaling and saturation of the finished accumulator.
    always_comb begin
        samp_ext_s = {{(ACC_W-DATA_W){sample_q[DATA_W-1]}}, sample_q};
        gain_ext_s = {{(ACC_W-GAIN_W){1'b0}}, gain_q[i_q[SEL_W-1:0]]};
        prod_s     = samp_ext_s * gain_ext_s;
        shifted_s  = acc_q >>> (GAIN_W - 1);
        // In range only when every bit above the sample MSB matches the sign.
        upper_s    = shifted_s[ACC_W-1:DATA_W-1];
        sat_s      = !((&upper_s) || (~|upper_s));
        if (sat_s) begin
            result_s = shifted_s[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                          : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result_s = shifted_s[DATA_W-1:0];
        end
        stop_s     = mix_abort | abort_q;
        k_inc_s    = k_q + LEN_W'(1'b1);
        clip_inc_s = (&clip_q) ? clip_q : (clip_q + LEN_W'(1'b1));
    end

    // Sequencer: state, datapath registers and registered bus/status outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clip_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            en_q     <= '0;
            gain_q   <= '0;
            len_q    <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            i_q      <= '0;
            sample_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (mix_start) begin
                        dst_q  <= mix_dst_addr;
                        src_q  <= mix_src_addr;
                        en_q   <= mix_src_en;
                        gain_q <= mix_gain;
                        len_q  <= mix_len;
                        acc_q  <= '0;
                        k_q    <= '0;
                        i_q    <= '0;
                        clip_q <= '0;
                        busy_q <= 1'b1;
                        if (mix_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SEL;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SEL: begin
                    if (stop_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (found_s) begin
                        i_q     <= sel_i_s;
                        addr_q  <= src_q[sel_i_s[SEL_W-1:0]] + ADDR_W'(k_q);
                        read_q  <= 1'b1;
                        state_q <= S_READ;
                    end else begin
                        addr_q  <= dst_q + ADDR_W'(k_q);
                        wdata_q <= result_s;
                        write_q <= 1'b1;
                        clip_q  <= sat_s ? clip_inc_s : clip_q;
                        state_q <= S_WRITE;
                    end
                end
                S_READ: begin
                    // A request is never retracted; an abort waits for its finished pulse.
                    abort_q <= stop_s;
                    if (bus.mix_read_finished) begin
                        read_q   <= 1'b0;
                        sample_q <= bus.mix_readdata;
                        if (stop_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end else begin
                        state_q <= S_READ;
                    end
                end
                S_ACC: begin
                    if (stop_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q   <= acc_q + prod_s;
                        i_q     <= i_q + IDX_W'(1'b1);
                        state_q <= S_SEL;
                    end
                end
                S_WRITE: begin
                    abort_q <= stop_s;
                    if (bus.mix_write_finished) begin
                        write_q <= 1'b0;
                        if (stop_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end else begin
                        state_q <= S_WRITE;
                    end
                end
                S_NEXT: begin
                    if (stop_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        k_q   <= k_inc_s;
                        i_q   <= '0;
                        acc_q <= '0;
                        if (k_inc_s == len_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SEL;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mix_core_n.md
Name: mix_core_n

Overview:
- Parametrised N-source audio mixer, successor to the fixed 5-address mixer.
- Reads one 16-bit sample at a time from up to N_SRC source tracks in SDRAM and applies a per-source gain to each.
- Sums the scaled samples with saturation and writes the result to a destination track, for mix_len samples.
- Sits between the top-level controller and the SDRAM access arbiter; uses the same read/write/finished handshake as the other SDRAM clients.

Parameters:
- ADDR_W, 23, SDRAM word-address width.
- DATA_W, 16, signed sample width.
- N_SRC, 4, number of source channels.
- GAIN_W, 8, unsigned gain width; unity gain = 2^(GAIN_W-1).
- LEN_W, 23, sample-count width.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- mix_start  in  1  start pulse; sampled only in IDLE.
- mix_abort  in  1  abort request; sampled every cycle.
- mix_dst_addr  in  ADDR_W  destination base address.
- mix_src_addr  in  N_SRC x ADDR_W  source base addresses.
- mix_src_en  in  N_SRC  per-source enable.
- mix_gain  in  N_SRC x GAIN_W  per-source gain.
- mix_len  in  LEN_W  number of samples to mix.
- mix_busy  out  1  high whenever the state is not IDLE.
- mix_done  out  1  one-cycle pulse on normal completion.
- mix_clip_count  out  LEN_W  number of output samples saturated in the last run.
- mix_read  out  1  SDRAM read request.
- mix_write  out  1  SDRAM write request.
- mix_addr  out  ADDR_W  SDRAM address.
- mix_writedata  out  DATA_W  SDRAM write data.
- mix_readdata  in  DATA_W  SDRAM read data.
- mix_read_finished  in  1  read complete; mix_readdata is valid this cycle.
- mix_write_finished  in  1  write complete.

Behaviour:
- Reset (i_rst=0, async):
  - State goes to IDLE.
  - All outputs are 0, including mix_clip_count.
  - Accumulator, sample index k and source index i are cleared.
- IDLE:
  - On mix_start=1, latch all config inputs, clear the accumulator, k and mix_clip_count, and go to SEL.
  - mix_start in any other state is ignored.
- SEL: advance i to the next enabled source with index ≥ i.
  - If one is found, go to READ.
  - If none is left, go to WRITE.
- READ:
  - mix_read=1 and mix_addr = src_addr[i]+k, taken modulo 2^ADDR_W (wrap-around).
  - Both are held stable until a cycle in which mix_read_finished=1.
  - In that cycle, capture mix_readdata and go to ACC; mix_read=0 in the following cycle.
- ACC (1 cycle):
  - acc += signed(sample) * unsigned(gain[i]).
  - Accumulator width is DATA_W+GAIN_W+clog2(N_SRC)+1, so it never overflows.
  - Then i++ and return to SEL.
- WRITE:
  - result = acc >>> (GAIN_W-1), arithmetic shift, truncating toward -inf.
  - Saturate result to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if saturation occurred, mix_clip_count++ (it saturates at its maximum value).
  - mix_write=1, mix_addr = dst_addr+k (modulo), mix_writedata = saturated result.
  - All held stable until mix_write_finished=1, then go to NEXT.
- NEXT:
  - k++, i=0, acc=0.
  - If k == len, go to DONE; otherwise go to SEL.
- DONE: mix_done=1 for exactly one cycle, then IDLE.
- Boundary cases:
  - len=0: IDLE → DONE directly; no SDRAM access.
  - All mix_src_en=0: each sample writes 0; there are len writes and no reads.
  - Read and write are never asserted simultaneously.
  - Per-sample cost is (enabled sources × (read latency+2)) + write latency + 2 cycles.
- mix_abort=1:
  - In IDLE or DONE: no effect.
  - In SEL, ACC or NEXT: go to IDLE next cycle; no mix_done.
  - In READ or WRITE: the pending request is held until its finished pulse, never retracted mid-transaction, then go to IDLE; no mix_done.
  - An abort is remembered once seen.
- A finished pulse arriving while no request is pending is ignored.
- Asserting reset mid-run returns to IDLE immediately; the SDRAM arbiter is responsible for discarding any in-flight request.

Test Plan:
- Unity single source: N_SRC=4, en=0001, gain0=128, len=4, src0 holds {100,-200,32767,-32768} → dst gets the same 4 values, clip_count=0, mix_done pulses once, 4 reads and 4 writes.
- Two-source sum with clip: en=0011, gains=128, src0=src1={20000,-20000,5} → dst={32767,-32768,10}, clip_count=2.
- Gain scaling: gain0=64, sample=-3 → acc=-192, result=-2 (floor); gain0=255, sample=1000 → 1992.
- Handshake stress: finished is delayed 0–7 random cycles → mix_addr and mix_read/mix_write stay stable until finished; the finished cycle is accepted; read and write never overlap.
- Boundary: len=0 → mix_done one cycle after start, no accesses; en=0000, len=3 → three writes of 0.
- Address wrap: dst=2^23-1, len=2 → writes to 0x7FFFFF then 0x000000.
- Abort in the middle of READ with finished delayed by 5 cycles → read is held until finished, then IDLE, no mix_done, busy=0.
